// File: rtl/ofdm_rx_byte_packer_if.sv
// ofdm_rx_byte_packer_if: dibit input stream and byte output handshake of the OFDM RX byte packer
interface ofdm_rx_byte_packer_if;
    logic [1:0] rcv_data_i;
    logic       rcv_data_valid_i;
    logic       rcv_data_start_i;
    logic [7:0] byte_o;
    logic       byte_sof_o;
    logic       byte_valid_o;
    logic       byte_ready_i;
    modport master (
        output rcv_data_i, rcv_data_valid_i, rcv_data_start_i, byte_ready_i,
        input  byte_o, byte_sof_o, byte_valid_o
    );
    modport slave (
        input  rcv_data_i, rcv_data_valid_i, rcv_data_start_i, byte_ready_i,
        output byte_o, byte_sof_o, byte_valid_o
    );
endinterface

// File: rtl/ofdm_rx_byte_packer.sv
// ofdm_rx_byte_packer: packs QPSK dibits MSB-first into SOF-tagged bytes behind a FIFO; OFDM_RX_PACK_STATS_EN builds the symbol counter
module ofdm_rx_byte_packer #(
    parameter int carriers_g   = 128,
    parameter int fifo_depth_g = 16
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_init_i,
    ofdm_rx_byte_packer_if.slave    bus,
    output logic                    overflow_o,
    output logic                    realign_o,
    output logic [15:0]             symbol_cnt_o
);
    localparam int AW = $clog2(fifo_depth_g);
    localparam int SW = $clog2(carriers_g + 1);
    localparam logic [SW-1:0] CAR = SW'(carriers_g);
    typedef enum logic {IDLE, PACK} state_t;
    state_t        state_q, state_d;
    logic [5:0]    pack_q, pack_d, base_reg;
    logic [1:0]    pos_q, pos_d, base_pos;
    logic [SW-1:0] sym_q, sym_d, base_sym, sym_n;
    logic          sof_q, sof_d, base_sof;
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [8:0]    mem_q [fifo_depth_g];
    logic [8:0]    wdata;
    logic [7:0]    byte_q, byte_d;
    logic          bsof_q, bsof_d, bval_q, bval_d, ovf_q, ovf_d, realign_q, realign_d;
    logic          restart, take, last, wr, wr_ok, pop, full;
    always_comb begin
        restart   = bus.rcv_data_valid_i & bus.rcv_data_start_i;
        take      = bus.rcv_data_valid_i & (restart | state_q == PACK);
        base_reg  = restart ? '0 : pack_q;
        base_pos  = restart ? '0 : pos_q;
        base_sym  = restart ? '0 : sym_q;
        base_sof  = restart | sof_q;
        sym_n     = base_sym + SW'(1);
        last      = sym_n == CAR;
        wr        = take & (base_pos == 2'd3 | last);
        wdata     = {base_sof, {base_reg, bus.rcv_data_i} << {2'd3 - base_pos, 1'b0}};
        state_d   = take ? (last ? IDLE : PACK) : state_q;
        pack_d    = take ? (last ? '0 : {base_reg[3:0], bus.rcv_data_i}) : pack_q;
        pos_d     = take ? (last ? '0 : base_pos + 2'd1) : pos_q;
        sym_d     = take ? (last ? '0 : sym_n) : sym_q;
        sof_d     = take ? base_sof & !wr : sof_q;
        realign_d = take & restart & (sym_q != '0);
        full      = (wp_q[AW] != rp_q[AW]) & (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop       = bval_q & bus.byte_ready_i;
        wr_ok     = wr & (!full | pop);
        ovf_d     = ovf_q | (wr & !wr_ok);
        wp_d      = wp_q + (AW+1)'(wr_ok);
        rp_d      = rp_q + (AW+1)'(pop);
        bval_d    = wp_d != rp_d;
        // a write landing in an empty FIFO becomes the head directly
        {bsof_d, byte_d} = !bval_d ? 9'd0 : (wr_ok && wp_q == rp_d) ? wdata : mem_q[rp_d[AW-1:0]];
    end
    always_ff @(posedge sys_clk_i) begin
        if (sys_init_i) begin
            state_q   <= IDLE;
            pack_q    <= '0;
            pos_q     <= '0;
            sym_q     <= '0;
            sof_q     <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            byte_q    <= '0;
            bsof_q    <= 1'b0;
            bval_q    <= 1'b0;
            ovf_q     <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pack_q    <= pack_d;
            pos_q     <= pos_d;
            sym_q     <= sym_d;
            sof_q     <= sof_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            byte_q    <= byte_d;
            bsof_q    <= bsof_d;
            bval_q    <= bval_d;
            ovf_q     <= ovf_d;
            realign_q <= realign_d;
        end
    end
    always_ff @(posedge sys_clk_i) begin
        if (wr_ok) mem_q[wp_q[AW-1:0]] <= wdata;
    end
`ifdef OFDM_RX_PACK_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + 16'(take & last);
    always_ff @(posedge sys_clk_i) begin
        if (sys_init_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign symbol_cnt_o = cnt_q;
`else
    assign symbol_cnt_o = '0;
`endif
    assign bus.byte_o       = byte_q;
    assign bus.byte_sof_o   = bsof_q;
    assign bus.byte_valid_o = bval_q;
    assign overflow_o       = ovf_q;
    assign realign_o        = realign_q;
endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// tb_ofdm_rx_byte_packer: randomized and directed checks of the byte packer against a queue-based symbol model
module tb_ofdm_rx_byte_packer;
    localparam int CARR  = 6;
    localparam int DEPTH = 16;
`ifdef OFDM_RX_PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        init;
    logic        ovf, realign;
    logic [15:0] symcnt;
    int          vectors = 0;
    int          miscompares = 0;
    bit          in_sym, sofn, m_ovf, m_realign;
    int          ndib;
    logic [15:0] nsym;
    int          part[$];
    logic [8:0]  q[$], obs[$], snap[$];

    always #5 clk = ~clk;

    ofdm_rx_byte_packer_if bus();

    ofdm_rx_byte_packer #(.carriers_g(CARR), .fifo_depth_g(DEPTH)) dut (
        .sys_clk_i   (clk),
        .sys_init_i  (init),
        .bus         (bus.slave),
        .overflow_o  (ovf),
        .realign_o   (realign),
        .symbol_cnt_o(symcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit rst, input bit v, input bit s, input logic [1:0] d, input bit rdy);
        bit pop, have;
        logic [8:0] b;
        if (rst) begin
            q.delete(); part.delete();
            in_sym = 0; sofn = 0; ndib = 0; nsym = '0; m_ovf = 0; m_realign = 0;
            return;
        end
        pop = q.size() > 0 && rdy;
        have = 0;
        b = '0;
        m_realign = 0;
        if (v && s) begin
            m_realign = in_sym && ndib > 0;
            in_sym = 1; ndib = 0; sofn = 1;
            part.delete();
        end
        if (v && in_sym) begin
            part.push_back(int'(d));
            ndib++;
            if (part.size() == 4 || ndib == CARR) begin
                b = {sofn, 8'h00};
                foreach (part[i]) b[7:0] = b[7:0] | 8'(part[i] << (6 - 2 * i));
                have = 1; sofn = 0;
                part.delete();
            end
            if (ndib == CARR) begin
                in_sym = 0;
                nsym++;
            end
        end
        if (pop) void'(q.pop_front());
        if (have) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1;
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit s, input logic [1:0] d, input bit rdy);
        init = rst;
        bus.rcv_data_valid_i = v;
        bus.rcv_data_start_i = s;
        bus.rcv_data_i = d;
        bus.byte_ready_i = rdy;
        if (!rst && bus.byte_valid_o === 1'b1 && rdy) obs.push_back({bus.byte_sof_o, bus.byte_o});
        @(posedge clk);
        model(rst, v, s, d, rdy);
        #1;
        chk("valid", 32'(bus.byte_valid_o), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("byte", 32'(bus.byte_o), 32'(q[0][7:0]));
            chk("sof", 32'(bus.byte_sof_o), 32'(q[0][8]));
        end
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("realign", 32'(realign), 32'(m_realign));
        chk("symcnt", 32'(symcnt), STATS ? 32'(nsym) : 32'd0);
    endtask

    task automatic rand_sym(input bit rdy);
        for (int i = 0; i < CARR; i++) step(0, 1, i == 0, 2'($urandom_range(3)), rdy);
    endtask

    initial begin
        repeat (2) step(1, 0, 0, 2'd0, 0);
        chk("rst_byte", 32'(bus.byte_o), 32'd0);
        chk("rst_sof", 32'(bus.byte_sof_o), 32'd0);
        // 1,1,1,1,2,2 -> 0x55 (sof) then zero-padded 0xA0
        obs.delete();
        step(0, 1, 1, 2'd1, 1);
        step(0, 1, 0, 2'd1, 1);
        step(0, 1, 0, 2'd1, 1);
        step(0, 1, 0, 2'd1, 1);
        step(0, 1, 0, 2'd2, 1);
        step(0, 1, 0, 2'd2, 1);
        repeat (3) step(0, 0, 0, 2'd0, 1);
        chk("pad_count", 32'(obs.size()), 32'd2);
        chk("pad_b0", 32'(obs[0]), 32'h155);
        chk("pad_b1", 32'(obs[1]), 32'h0A0);
        // restart after two dibits: partial dropped, next byte tagged SOF
        obs.delete();
        step(0, 1, 1, 2'd2, 1);
        step(0, 1, 0, 2'd2, 1);
        step(0, 1, 1, 2'd0, 1);
        chk("realign_pulse", 32'(realign), 32'd1);
        step(0, 1, 0, 2'd0, 1);
        step(0, 1, 0, 2'd0, 1);
        step(0, 1, 0, 2'd3, 1);
        step(0, 1, 0, 2'd1, 1);
        step(0, 1, 0, 2'd1, 1);
        repeat (3) step(0, 0, 0, 2'd0, 1);
        chk("realign_count", 32'(obs.size()), 32'd2);
        chk("realign_b0", 32'(obs[0]), 32'h103);
        chk("realign_b1", 32'(obs[1]), 32'h050);
        // 18 bytes into a blocked 16-entry FIFO, then drain
        step(1, 0, 0, 2'd0, 0);
        repeat (9) rand_sym(0);
        chk("ovf_set", 32'(ovf), 32'd1);
        snap = q;
        obs.delete();
        repeat (20) step(0, 0, 0, 2'd0, 1);
        chk("drain_count", 32'(obs.size()), 32'd16);
        foreach (snap[i]) chk("drain_order", 32'(obs[i]), 32'(snap[i]));
        // full FIFO: pop and write on the same edge keeps it full without overflow
        step(1, 0, 0, 2'd0, 0);
        repeat (8) rand_sym(0);
        step(0, 1, 1, 2'd1, 0);
        step(0, 1, 0, 2'd2, 0);
        step(0, 1, 0, 2'd3, 0);
        step(0, 1, 0, 2'd0, 1);
        chk("fullpw_no_ovf", 32'(ovf), 32'd0);
        step(0, 1, 0, 2'd1, 0);
        step(0, 1, 0, 2'd1, 0);
        chk("fullpw_still_full", 32'(ovf), 32'd1);
        // init with five bytes queued
        step(1, 0, 0, 2'd0, 0);
        repeat (2) rand_sym(0);
        for (int i = 0; i < 4; i++) step(0, 1, i == 0, 2'd3, 0);
        chk("init_pre_valid", 32'(bus.byte_valid_o), 32'd1);
        step(1, 1, 0, 2'd3, 0);
        chk("init_valid", 32'(bus.byte_valid_o), 32'd0);
        chk("init_byte", 32'(bus.byte_o), 32'd0);
        chk("init_sof", 32'(bus.byte_sof_o), 32'd0);
        chk("init_ovf", 32'(ovf), 32'd0);
        chk("init_symcnt", 32'(symcnt), 32'd0);
        repeat (3000)
            step($urandom_range(499) == 0, $urandom_range(9) < 7, $urandom_range(11) == 0,
                 2'($urandom_range(3)), $urandom_range(9) < 6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
